frame_buf_wr: RTL and testbench
===============================

Name: frame_buf_wr

Overview:
- Parametrised successor to the single-frame FIFO-to-BRAM writer.
- Drains a FIFO of SOF-tagged pixels from the capture clock-domain crossing and writes complete frames into BRAM.
- Supports configurable pixel width and resolution, optional double (ping-pong) buffering, SOF resynchronisation and frame-level status.
- Sits between the capture FIFO and the frame-buffer BRAM; the display reader uses o_rd_bank and o_frame_valid.

Parameters:
- DATA_W, 12, pixel width in bits.
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- DOUBLE_BUF, 1, 1 = two frame banks (ping-pong), 0 = single bank.
- FRAME = H_ACTIVE*V_ACTIVE (derived).
- ADDR_W = clog2(FRAME*(DOUBLE_BUF+1)) (derived).

Ports:
- i_clk  in  1  system clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_en  in  1  capture enable.
- o_rd  out  1  FIFO read strobe.
- i_data  in  DATA_W+1  FIFO word; bit DATA_W = SOF flag, bits DATA_W-1:0 = pixel.
- i_empty  in  1  FIFO empty.
- o_wr  out  1  BRAM write enable.
- o_waddr  out  ADDR_W  BRAM write address.
- o_wdata  out  DATA_W  BRAM write data.
- o_rd_bank  out  1  bank holding the most recent complete frame.
- o_frame_valid  out  1  at least one complete frame written since reset.
- o_frame_done  out  1  one-cycle pulse, frame complete.
- o_err_short  out  1  one-cycle pulse, SOF arrived mid-frame.

Behaviour:
- Reset, asynchronous, i_rstn low: state IDLE. o_rd, o_wr, o_waddr, o_wdata, o_rd_bank, o_frame_valid, o_frame_done and o_err_short are all 0. Write bank wbank=0, offset=0.
- FIFO timing: read latency 1. A word is valid in the cycle after o_rd=1 (internal flag vld = o_rd delayed one cycle). o_rd is registered, o_rd = !i_empty && state!=IDLE. The FIFO guards against read-when-empty.
- BRAM outputs are registered: o_wr, o_waddr and o_wdata appear in the cycle after vld, giving rd-to-wr latency 2. At most one write per cycle. No backpressure.
- Bank base address: 0 for bank 0, FRAME for bank 1. Form it by selection, never by a runtime multiply. o_waddr = base(wbank) + offset.
- States:
  - IDLE: no reads. Go to SYNC when i_en=1.
  - SYNC: read continuously. A vld word with SOF=0 is dropped (no write). A vld word with SOF=1 is written at offset 0, then offset=1 and go to ACTIVE. If i_en=0 and no vld word, return to IDLE.
  - ACTIVE, vld with SOF=0: write at offset, offset+1.
  - ACTIVE, vld with SOF=1 and offset!=0: pulse o_err_short. Write this pixel at offset 0 of the same bank, offset=1. No bank swap, status unchanged.
  - ACTIVE, write at offset FRAME-1 (last pixel): offset=0 and o_frame_done pulses in the same cycle as that o_wr. o_rd_bank<=wbank and o_frame_valid<=1. If DOUBLE_BUF then wbank toggles, else wbank stays 0. Go to SYNC, or to IDLE if i_en=0. In-flight words after o_rd drops are still handled in SYNC rules.
- A vld word with SOF=1 arriving while offset==0 in ACTIVE cannot occur. Offset==0 in ACTIVE is unreachable.
- i_en deassert mid-frame: the current frame finishes; i_en is checked only at frame end and in SYNC.
- Empty gaps mid-frame: hold offset and state, no error.
- Offset counter width is clog2(FRAME). It wraps only via the frame-end rule, never by overflow.
- Reset mid-frame: the partial frame is abandoned. Status reverts to reset values. The next frame needs SOF.

Test Plan:
- Reset, i_en=1, FIFO streams 2 full frames (SOF on first pixel, pixel=index mod 4096), DOUBLE_BUF=1 -> frame 0 writes addr 0..307199 and frame 1 writes 307200..614399. o_frame_done pulses twice. o_rd_bank goes 0 then 1. o_frame_valid=1 after the first pulse.
- 100 non-SOF words before the first SOF -> no o_wr until the SOF pixel, which is written to addr 0.
- SOF injected at pixel 1000 of a frame -> o_err_short pulses once, that pixel is written to addr base+0, subsequent pixels continue from base+1, and o_rd_bank is unchanged.
- Random i_empty gaps (50% duty) over a full frame -> exactly 307200 writes with contiguous addresses, data matches FIFO order, rd-to-wr latency 2 on every word.
- i_en dropped at pixel 5000 -> frame completes to addr FRAME-1, then o_rd stays 0 (state IDLE). DOUBLE_BUF=0 repeat -> both frames write addr 0..307199 and o_rd_bank stays 0.
- i_rstn asserted at pixel 2000 asynchronously (mid-cycle) -> all outputs 0 immediately. After release, the next SOF frame writes from addr 0.

Source files
------------

// File: rtl/frame_buf_wr.sv
// Drains a latency-1 FIFO of SOF-tagged pixels into frame-buffer BRAM, with optional
// ping-pong banking, SOF resynchronisation and frame-level status.
module frame_buf_wr #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned DOUBLE_BUF = 1,
  localparam int unsigned FRAME     = H_ACTIVE * V_ACTIVE,
  localparam int unsigned ADDR_W    = $clog2(FRAME * (DOUBLE_BUF + 1))
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  output logic              o_rd,
  input  logic [DATA_W:0]   i_data,
  input  logic              i_empty,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_rd_bank,
  output logic              o_frame_valid,
  output logic              o_frame_done,
  output logic              o_err_short
);

  localparam int unsigned       OFF_W     = $clog2(FRAME);
  localparam logic [OFF_W-1:0]  LastOff   = OFF_W'(FRAME - 1);
  localparam logic [ADDR_W-1:0] Bank1Base = ADDR_W'(FRAME);

  typedef enum logic [1:0] {StIdle, StSync, StActive} state_e;

  state_e              state_q, state_d;
  logic                rd_q, vld_q;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                bank_q, bank_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_bank_q, rd_bank_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                sof;
  logic [DATA_W-1:0]   px;
  logic                do_wr;
  logic [OFF_W-1:0]    woff;
  logic [ADDR_W-1:0]   base;

  assign sof  = i_data[DATA_W];
  assign px   = i_data[DATA_W-1:0];
  assign base = (bank_q && (DOUBLE_BUF != 0)) ? Bank1Base : '0;

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    bank_d    = bank_q;
    wr_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rd_bank_d = rd_bank_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    do_wr     = 1'b0;
    woff      = '0;

    unique case (state_q)
      // Words still in flight after o_rd drops are resolved with the SYNC rules here too.
      StIdle, StSync: begin
        if (vld_q && sof) begin
          do_wr = 1'b1;
        end else if (state_q == StIdle) begin
          if (i_en) state_d = StSync;
        end else if (!vld_q && !i_en) begin
          state_d = StIdle;
        end
      end
      StActive: begin
        if (vld_q) begin
          do_wr = 1'b1;
          if (sof) begin
            err_d = (off_q != '0);
          end else begin
            woff = off_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_wr) begin
      wr_d    = 1'b1;
      waddr_d = base + ADDR_W'(woff);
      wdata_d = px;
      if (woff == LastOff) begin
        off_d     = '0;
        done_d    = 1'b1;
        rd_bank_d = bank_q;
        valid_d   = 1'b1;
        bank_d    = (DOUBLE_BUF != 0) ? ~bank_q : 1'b0;
        state_d   = i_en ? StSync : StIdle;
      end else begin
        off_d   = woff + OFF_W'(1);
        state_d = StActive;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= StIdle;
      rd_q      <= 1'b0;
      vld_q     <= 1'b0;
      off_q     <= '0;
      bank_q    <= 1'b0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rd_bank_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= !i_empty && (state_q != StIdle);
      vld_q     <= rd_q;
      off_q     <= off_d;
      bank_q    <= bank_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rd_bank_q <= rd_bank_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_rd          = rd_q;
  assign o_wr          = wr_q;
  assign o_waddr       = waddr_q;
  assign o_wdata       = wdata_q;
  assign o_rd_bank     = rd_bank_q;
  assign o_frame_valid = valid_q;
  assign o_frame_done  = done_q;
  assign o_err_short   = err_q;

endmodule

// File: tb/tb_frame_buf_wr.sv
// Bench for frame_buf_wr: a small-frame double-buffered and single-bank instance share one
// FIFO model; a frame-level model predicts every write and status output.
module tb_frame_buf_wr;
  localparam int unsigned DW    = 12;
  localparam int unsigned H     = 8;
  localparam int unsigned V     = 4;
  localparam int unsigned FRAME = H * V;
  localparam int unsigned AW0   = $clog2(2 * FRAME);
  localparam int unsigned AW1   = $clog2(FRAME);

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          en = 1'b0;
  logic          empty = 1'b1;
  logic [DW:0]   data = '0;

  logic          rd_a, wr_a, rdbank_a, valid_a, done_a, err_a;
  logic [AW0-1:0] waddr_a;
  logic [DW-1:0] wdata_a;
  logic          rd_b, wr_b, rdbank_b, valid_b, done_b, err_b;
  logic [AW1-1:0] waddr_b;
  logic [DW-1:0] wdata_b;

  frame_buf_wr #(.DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .DOUBLE_BUF(1)) u_dut_db (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .o_rd(rd_a), .i_data(data), .i_empty(empty),
    .o_wr(wr_a), .o_waddr(waddr_a), .o_wdata(wdata_a), .o_rd_bank(rdbank_a),
    .o_frame_valid(valid_a), .o_frame_done(done_a), .o_err_short(err_a)
  );

  frame_buf_wr #(.DATA_W(DW), .H_ACTIVE(H), .V_ACTIVE(V), .DOUBLE_BUF(0)) u_dut_sb (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .o_rd(rd_b), .i_data(data), .i_empty(empty),
    .o_wr(wr_b), .o_waddr(waddr_b), .o_wdata(wdata_b), .o_rd_bank(rdbank_b),
    .o_frame_valid(valid_b), .o_frame_done(done_b), .o_err_short(err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit wr; int addr; int data; bit done; bit err; bit rdbank; bit valid;
  } exp_t;

  logic [DW:0] fifo[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   gaps = 1'b0;
  bit   rd_prev = 1'b0;
  bit   empty_prev = 1'b1;

  // Frame-level model: synced flag, next pixel index, bank being filled, published status.
  bit   m_act[2];
  int   m_off[2], m_bank[2];
  bit   m_rdbank[2], m_valid[2];
  exp_t ex_cur[2], ex_nxt[2];

  int   ph_wr[2], ph_done[2], ph_err[2], ph_last[2], ph_first_addr[2], ph_first_data[2];
  bit   ph_seen[2];

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_off[d] = 0; m_bank[d] = 0; m_rdbank[d] = 0; m_valid[d] = 0;
      ex_cur[d] = '{0, 0, 0, 0, 0, 0, 0};
      ex_nxt[d] = '{0, 0, 0, 0, 0, 0, 0};
    end
  endtask

  task automatic model_word(int d, bit sof, int px);
    int woff = 0;
    bit w = 0;
    ex_nxt[d] = '{0, 0, 0, 0, 0, 0, 0};
    if (!m_act[d]) begin
      if (sof) w = 1;
    end else begin
      w = 1;
      if (sof) ex_nxt[d].err = 1;
      else woff = m_off[d];
    end
    if (w) begin
      ex_nxt[d].wr   = 1;
      ex_nxt[d].addr = m_bank[d] * FRAME + woff;
      ex_nxt[d].data = px;
      if (woff == FRAME - 1) begin
        ex_nxt[d].done = 1;
        m_rdbank[d] = m_bank[d][0];
        m_valid[d]  = 1;
        m_bank[d]   = (d == 0) ? 1 - m_bank[d] : 0;
        m_off[d]    = 0;
        m_act[d]    = 0;
      end else begin
        m_off[d] = woff + 1;
        m_act[d] = 1;
      end
    end
    ex_nxt[d].rdbank = m_rdbank[d];
    ex_nxt[d].valid  = m_valid[d];
  endtask

  task automatic model_idle(int d);
    ex_nxt[d] = '{0, 0, 0, 0, 0, m_rdbank[d], m_valid[d]};
  endtask

  task automatic cmp(int d, logic wr, logic [31:0] addr, logic [31:0] dat, logic dn, logic er,
                     logic rb, logic vl);
    chk("wr", d, {31'd0, wr}, {31'd0, ex_cur[d].wr});
    if (ex_cur[d].wr) begin
      chk("waddr", d, addr, ex_cur[d].addr);
      chk("wdata", d, dat, ex_cur[d].data);
    end
    chk("frame_done", d, {31'd0, dn}, {31'd0, ex_cur[d].done});
    chk("err_short", d, {31'd0, er}, {31'd0, ex_cur[d].err});
    chk("rd_bank", d, {31'd0, rb}, {31'd0, ex_cur[d].rdbank});
    chk("frame_valid", d, {31'd0, vl}, {31'd0, ex_cur[d].valid});
  endtask

  task automatic observe(int d, logic wr, int addr, int dat, logic dn, logic er);
    if (wr) begin
      ph_wr[d]++;
      ph_last[d] = addr;
      if (!ph_seen[d]) begin
        ph_seen[d] = 1; ph_first_addr[d] = addr; ph_first_data[d] = dat;
      end
    end
    if (dn) ph_done[d]++;
    if (er) ph_err[d]++;
  endtask

  task automatic new_phase();
    for (int d = 0; d < 2; d++) begin
      ph_wr[d] = 0; ph_done[d] = 0; ph_err[d] = 0; ph_last[d] = -1;
      ph_first_addr[d] = -1; ph_first_data[d] = -1; ph_seen[d] = 0;
    end
  endtask

  task automatic push_frame(int base, int n);
    logic [DW:0] w;
    for (int i = 0; i < n; i++) begin
      w = {1'b0, DW'((base + i) % 4096)};
      w[DW] = (i == 0);
      fifo.push_back(w);
    end
  endtask

  task automatic push_nonsof(int base, int n);
    for (int i = 0; i < n; i++) fifo.push_back({1'b0, DW'((base + i) % 4096)});
  endtask

  // One clock: FIFO delivers the word read last cycle, model predicts, outputs compared.
  task automatic step();
    logic [DW:0] w;
    int avail;
    @(posedge clk);
    #1;
    ex_cur = ex_nxt;
    if (rd_prev && fifo.size() != 0) begin
      w = fifo.pop_front();
      data = w;
      for (int d = 0; d < 2; d++) model_word(d, w[DW], int'(w[DW-1:0]));
    end else begin
      if (rd_prev) chk("read_when_empty", 0, 32'(fifo.size()), 1);
      data = (DW + 1)'($urandom);
      for (int d = 0; d < 2; d++) model_idle(d);
    end
    avail = fifo.size() - (rd_a ? 1 : 0);
    empty = (avail <= 0) || (gaps && ($urandom_range(1, 0) == 1));
    @(negedge clk);
    cmp(0, wr_a, 32'(waddr_a), 32'(wdata_a), done_a, err_a, rdbank_a, valid_a);
    cmp(1, wr_b, 32'(waddr_b), 32'(wdata_b), done_b, err_b, rdbank_b, valid_b);
    chk("rd_guard", 0, {31'd0, rd_a && empty_prev}, 0);
    chk("rd_match", 1, {31'd0, rd_b}, {31'd0, rd_a});
    observe(0, wr_a, int'(waddr_a), int'(wdata_a), done_a, err_a);
    observe(1, wr_b, int'(waddr_b), int'(wdata_b), done_b, err_b);
    rd_prev    = rd_a;
    empty_prev = empty;
  endtask

  task automatic drain();
    int quiet = 0;
    int n = 0;
    while (quiet < 8 && n < 2000) begin
      step();
      n++;
      quiet = (fifo.size() == 0 && !rd_a) ? quiet + 1 : 0;
    end
    if (n >= 2000) begin
      n_cmp++; n_mis++;
      $display("FAIL drain_timeout t=%0t: fifo left %0d words", $time, fifo.size());
    end
  endtask

  task automatic run_until_wr(int k);
    int n = 0;
    while (ph_wr[0] < k && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      n_cmp++; n_mis++;
      $display("FAIL wr_wait_timeout t=%0t: got %0d writes expected %0d", $time, ph_wr[0], k);
    end
  endtask

  task automatic reset_outputs_check(string name);
    chk(name, 0, 32'({rd_a, wr_a, waddr_a, wdata_a, rdbank_a, valid_a, done_a, err_a}), 0);
    chk(name, 1, 32'({rd_b, wr_b, waddr_b, wdata_b, rdbank_b, valid_b, done_b, err_b}), 0);
  endtask

  task automatic reset_mid();
    #2 rstn = 1'b0;
    #1 reset_outputs_check("async_reset_outputs");
    fifo.delete();
    model_reset();
    rd_prev = 0; empty_prev = 1; empty = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t: bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    new_phase();
    #2 rstn = 1'b0;
    #1 reset_outputs_check("reset_outputs");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    en = 1'b1;

    // Two back-to-back frames.
    new_phase();
    push_frame(0, FRAME);
    push_frame(FRAME, FRAME);
    drain();
    chk("t1_writes", 0, ph_wr[0], 2 * FRAME);
    chk("t1_done", 0, ph_done[0], 2);
    chk("t1_last_addr", 0, ph_last[0], 2 * FRAME - 1);
    chk("t1_last_addr", 1, ph_last[1], FRAME - 1);
    chk("t1_rd_bank", 0, {31'd0, rdbank_a}, 1);
    chk("t1_rd_bank", 1, {31'd0, rdbank_b}, 0);
    chk("t1_valid", 0, {31'd0, valid_a}, 1);

    // Junk before SOF is dropped.
    new_phase();
    push_nonsof(2748, 10);
    push_frame(500, FRAME);
    drain();
    chk("t2_first_addr", 0, ph_first_addr[0], 0);
    chk("t2_first_data", 0, ph_first_data[0], 500);
    chk("t2_writes", 0, ph_wr[0], FRAME);

    // SOF arrives at pixel 10 of a bank-1 frame.
    new_phase();
    push_frame(100, 10);
    push_frame(200, FRAME);
    drain();
    chk("t3_err", 0, ph_err[0], 1);
    chk("t3_writes", 0, ph_wr[0], 10 + FRAME);
    chk("t3_done", 0, ph_done[0], 1);
    chk("t3_rd_bank", 0, {31'd0, rdbank_a}, 1);

    // Random empty gaps.
    new_phase();
    gaps = 1'b1;
    push_frame(300, FRAME);
    drain();
    gaps = 1'b0;
    chk("t4_writes", 0, ph_wr[0], FRAME);
    chk("t4_last_addr", 0, ph_last[0], FRAME - 1);

    // i_en dropped mid-frame: frame completes, then reads stop.
    new_phase();
    push_frame(400, FRAME);
    run_until_wr(5);
    en = 1'b0;
    drain();
    chk("t5_writes", 0, ph_wr[0], FRAME);
    chk("t5_last_addr", 0, ph_last[0], 2 * FRAME - 1);
    chk("t5_last_addr", 1, ph_last[1], FRAME - 1);
    push_frame(600, 5);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_rd_idle", 0, {31'd0, rd_a}, 0);
    end
    en = 1'b1;
    drain();

    // Asynchronous reset mid-frame, then a fresh frame.
    new_phase();
    push_frame(700, FRAME);
    run_until_wr(12);
    reset_mid();
    new_phase();
    push_nonsof(50, 3);
    push_frame(900, FRAME);
    drain();
    chk("t6_first_addr", 0, ph_first_addr[0], 0);
    chk("t6_first_addr", 1, ph_first_addr[1], 0);
    chk("t6_first_data", 0, ph_first_data[0], 900);
    chk("t6_done", 0, ph_done[0], 1);
    chk("t6_rd_bank", 0, {31'd0, rdbank_a}, 0);
    chk("t6_valid", 0, {31'd0, valid_a}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
